// File: rtl/axi_burst_write_master.sv
// axi_burst_write_master: AXI3-style write-burst master with strobe generation and B-response collection
module axi_burst_write_master #(
  parameter int WIDTH = 32,
  parameter int SIZE = 3,
  parameter int TIMEOUT = 256,
  localparam int NB = WIDTH / 8,
  localparam int LB = $clog2(NB),
  localparam int TW = $clog2(TIMEOUT + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_addr,
  input  logic [NB-1:0]    cmd_id,
  input  logic [NB-1:0]    cmd_len,
  input  logic [SIZE-1:0]  cmd_size,
  input  logic [SIZE-2:0]  cmd_burst,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [WIDTH-1:0] wr_data,
  output logic             AWVALID,
  input  logic             AWREADY,
  output logic [WIDTH-1:0] AWADDR,
  output logic [NB-1:0]    AWID,
  output logic [NB-1:0]    AWLEN,
  output logic [SIZE-1:0]  AWSIZE,
  output logic [SIZE-2:0]  AWBURST,
  output logic             WVALID,
  input  logic             WREADY,
  output logic [WIDTH-1:0] WDATA,
  output logic [NB-1:0]    WSTRB,
  output logic             WLAST,
  output logic [NB-1:0]    WID,
  input  logic             BVALID,
  output logic             BREADY,
  input  logic [NB-1:0]    BID,
  input  logic [SIZE-2:0]  BRESP,
  output logic             busy,
  output logic             done,
  output logic [SIZE-2:0]  done_resp,
  output logic [2:0]       done_flags
);
  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;
  localparam logic [SIZE-2:0] FIXED = (SIZE-1)'(0);
  localparam logic [SIZE-2:0] WRAP = (SIZE-1)'(2);
  localparam logic [SIZE-2:0] RSVD = (SIZE-1)'(3);
  localparam logic [SIZE-2:0] SLVERR = (SIZE-1)'(2);
  state_t state;
  logic [WIDTH-1:0] cur_addr, nxt_addr, sz, wmask;
  logic [NB:0] bcnt;
  logic [TW-1:0] tcnt;
  logic [NB-1:0] span, strb;
  logic bad, load, last;
  // Legality of the command currently on the bus: size, burst encoding, wrap length and alignment
  always_comb begin
    bad = (cmd_size > SIZE'(LB)) || (cmd_burst == RSVD) ||
          (cmd_burst == WRAP && (!(cmd_len inside {NB'(1), NB'(3), NB'(7), NB'(15)}) ||
           ((cmd_addr & ((WIDTH'(1) << cmd_size) - WIDTH'(1))) != '0)));
  end
  // Strobe of the beat being loaded, address of the beat after it, and the W load handshake
  always_comb begin
    sz = WIDTH'(1) << AWSIZE;
    wmask = ((WIDTH'(AWLEN) + WIDTH'(1)) << AWSIZE) - WIDTH'(1);
    nxt_addr = (AWBURST == FIXED) ? cur_addr :
               (AWBURST == WRAP) ? ((cur_addr & ~wmask) | ((cur_addr + sz) & wmask)) :
               ((cur_addr & ~(sz - WIDTH'(1))) + sz);
    span = {NB{1'b1}} >> (NB - (1 << AWSIZE));
    strb = NB'({{NB{1'b0}}, span} << cur_addr[LB-1:0]);
    last = bcnt == {1'b0, AWLEN};
    wr_ready = (state == DATA) && (!WVALID || WREADY) && (bcnt <= {1'b0, AWLEN});
    load = wr_valid && wr_ready;
    WID = AWID;
    busy = state != IDLE;
  end
  // Burst FSM: command capture, AW issue, one-entry W register, B collection and completion pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cmd_ready <= 1'b0;
      AWVALID <= 1'b0;
      AWADDR <= '0;
      AWID <= '0;
      AWLEN <= '0;
      AWSIZE <= '0;
      AWBURST <= '0;
      WVALID <= 1'b0;
      WDATA <= '0;
      WSTRB <= '0;
      WLAST <= 1'b0;
      BREADY <= 1'b0;
      done <= 1'b0;
      done_resp <= '0;
      done_flags <= '0;
      cur_addr <= '0;
      bcnt <= '0;
      tcnt <= '0;
    end else begin
      done <= 1'b0;
      done_resp <= '0;
      done_flags <= '0;
      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready && bad) begin
            done <= 1'b1;
            done_resp <= SLVERR;
            done_flags <= 3'b100;
          end else if (cmd_valid && cmd_ready) begin
            state <= ADDR;
            cmd_ready <= 1'b0;
            AWVALID <= 1'b1;
            AWADDR <= cmd_addr;
            AWID <= cmd_id;
            AWLEN <= cmd_len;
            AWSIZE <= cmd_size;
            AWBURST <= cmd_burst;
            cur_addr <= cmd_addr;
            bcnt <= '0;
          end
        end
        ADDR: begin
          if (AWREADY) begin
            AWVALID <= 1'b0;
            state <= DATA;
          end
        end
        DATA: begin
          if (load) begin
            WVALID <= 1'b1;
            WDATA <= wr_data;
            WSTRB <= strb;
            WLAST <= last;
            bcnt <= bcnt + 1'b1;
            cur_addr <= nxt_addr;
          end else if (WREADY) begin
            WVALID <= 1'b0;
            WLAST <= 1'b0;
          end
          if (WVALID && WREADY && WLAST) begin
            state <= RESP;
            BREADY <= 1'b1;
            tcnt <= '0;
          end
        end
        RESP: begin
          if (BVALID && BREADY) begin
            state <= IDLE;
            cmd_ready <= 1'b1;
            BREADY <= 1'b0;
            done <= 1'b1;
            done_resp <= BRESP;
            done_flags <= {2'b00, BID != AWID};
          end else if (tcnt == TW'(TIMEOUT - 1)) begin
            state <= IDLE;
            cmd_ready <= 1'b1;
            BREADY <= 1'b0;
            done <= 1'b1;
            done_resp <= SLVERR;
            done_flags <= 3'b010;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_burst_write_master.sv
// tb_axi_burst_write_master: randomized scoreboard bench for the AXI write-burst master
module tb_axi_burst_write_master;
  localparam int TO = 16;
  logic clk = 0, reset = 0;
  logic cmd_valid = 0, cmd_ready;
  logic [31:0] cmd_addr = 0;
  logic [3:0] cmd_id = 0, cmd_len = 0;
  logic [2:0] cmd_size = 0;
  logic [1:0] cmd_burst = 0;
  logic wr_valid, wr_ready;
  logic [31:0] wr_data;
  logic AWVALID, AWREADY;
  logic [31:0] AWADDR;
  logic [3:0] AWID, AWLEN;
  logic [2:0] AWSIZE;
  logic [1:0] AWBURST;
  logic WVALID, WREADY, WLAST;
  logic [31:0] WDATA;
  logic [3:0] WSTRB, WID;
  logic BVALID, BREADY;
  logic [3:0] BID;
  logic [1:0] BRESP;
  logic busy, done;
  logic [1:0] done_resp;
  logic [2:0] done_flags;

  axi_burst_write_master #(.WIDTH(32), .SIZE(3), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_id(cmd_id),
    .cmd_len(cmd_len), .cmd_size(cmd_size), .cmd_burst(cmd_burst),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWID(AWID), .AWLEN(AWLEN),
    .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WID(WID),
    .BVALID(BVALID), .BREADY(BREADY), .BID(BID), .BRESP(BRESP),
    .busy(busy), .done(done), .done_resp(done_resp), .done_flags(done_flags)
  );

  always #5 clk = ~clk;

  typedef struct { longint v; int kind; } done_t;
  longint exp_aw[$], exp_w[$];
  done_t exp_d[$];
  logic [31:0] wq[$];
  int npass = 0, ntot = 0, cyc = 0, w_seen = 0, aw_seen = 0;
  int acc_cyc = 0, lastw_cyc = 0, bhs_cyc = 0;
  bit w_last_flag = 0, b_hs = 0, b_never = 0, gaps = 0, aw_rand = 0, stall = 0, feed_t = 0;
  int b_delay = 0, bwait = -1, wmode = 0;
  logic [3:0] b_id = 0;
  logic [1:0] b_resp = 0;
  logic [36:0] held = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    ntot++;
    if (act == exp) npass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [3:0] strb_of(input int unsigned a, input int unsigned k, input int unsigned len,
                                         input int unsigned size, input int unsigned burst);
    int unsigned s, b, ba;
    s = 1 << size;
    if (burst == 0) ba = a;
    else if (burst == 1) ba = (k == 0) ? a : (a / s * s) + k * s;
    else begin
      b = (len + 1) * s;
      ba = (a / b * b) + (a + k * s) % b;
    end
    return 4'(((1 << s) - 1) << (ba % 4));
  endfunction

  // Monitor: pops the scoreboard whenever the DUT presents a handshake or completion
  initial forever begin
    done_t d;
    @(negedge clk);
    if (!reset) begin
      stall = 0;
      continue;
    end
    if (stall) chk("w_hold", {WVALID, WDATA, WSTRB, WLAST}, {1'b1, held});
    stall = WVALID && !WREADY;
    held = {WDATA, WSTRB, WLAST};
    if (cmd_valid && cmd_ready) acc_cyc = cyc;
    if (AWVALID) aw_seen++;
    if (AWVALID && AWREADY) begin
      if (exp_aw.size() == 0) chk("aw_unexpected", 1, 0);
      else chk("aw_fields", {AWADDR, AWID, AWLEN, AWSIZE, AWBURST}, exp_aw.pop_front());
    end
    if (WVALID && WREADY) begin
      w_seen++;
      if (exp_w.size() == 0) chk("w_unexpected", 1, 0);
      else chk("w_beat", {WDATA, WSTRB, WLAST, WID}, exp_w.pop_front());
      if (WLAST) begin
        w_last_flag = 1;
        lastw_cyc = cyc;
      end
    end
    if (BVALID && BREADY) begin
      b_hs = 1;
      bhs_cyc = cyc;
    end
    if (done) begin
      if (exp_d.size() == 0) chk("done_unexpected", 1, 0);
      else begin
        d = exp_d.pop_front();
        chk("done_status", {done_resp, done_flags}, d.v);
        chk("done_latency", cyc - (d.kind == 0 ? acc_cyc : d.kind == 1 ? lastw_cyc : bhs_cyc),
            d.kind == 1 ? TO + 1 : 1);
      end
    end else if (done_resp != 0 || done_flags != 0) chk("status_idle_zero", {done_resp, done_flags}, 0);
  end

  // Local data source, optionally with gaps
  initial begin
    wr_valid = 0;
    wr_data = 0;
    forever begin
      @(negedge clk);
      feed_t = wr_valid && wr_ready;
      @(posedge clk);
      #1;
      if (feed_t && wq.size() > 0) void'(wq.pop_front());
      if (wq.size() > 0 && (!gaps || $urandom_range(2) != 0)) begin
        wr_valid = 1;
        wr_data = wq[0];
      end else wr_valid = 0;
    end
  end

  // Slave ready behaviour: tied, toggling or random
  initial begin
    AWREADY = 0;
    WREADY = 0;
    forever begin
      @(posedge clk);
      #1;
      AWREADY = aw_rand ? 1'($urandom_range(1)) : 1'b1;
      WREADY = (wmode == 0) ? 1'b1 : (wmode == 1) ? ~WREADY : 1'($urandom_range(1));
    end
  end

  // Slave B channel: respond b_delay cycles after the last W beat unless told to stay silent
  initial begin
    BVALID = 0;
    BID = 0;
    BRESP = 0;
    forever begin
      @(posedge clk);
      #1;
      if (b_hs) begin
        BVALID = 0;
        b_hs = 0;
      end
      if (w_last_flag) begin
        w_last_flag = 0;
        if (!b_never) bwait = b_delay;
      end
      if (bwait == 0) begin
        BVALID = 1;
        BID = b_id;
        BRESP = b_resp;
        bwait = -1;
      end else if (bwait > 0) bwait--;
    end
  end

  task automatic flush();
    exp_aw.delete();
    exp_w.delete();
    exp_d.delete();
    wq.delete();
    w_last_flag = 0;
    b_hs = 0;
    bwait = -1;
    BVALID = 0;
  endtask

  task automatic issue(input logic [31:0] a, input logic [3:0] id, input logic [3:0] len,
                       input logic [2:0] size, input logic [1:0] burst);
    int n = 0;
    @(posedge clk);
    #1;
    cmd_valid = 1;
    cmd_addr = a;
    cmd_id = id;
    cmd_len = len;
    cmd_size = size;
    cmd_burst = burst;
    do begin
      @(negedge clk);
      n++;
    end while (!cmd_ready && n < 200);
    if (!cmd_ready) chk("cmd_accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    cmd_valid = 0;
  endtask

  task automatic push_expect(input logic [31:0] a, input logic [3:0] id, input logic [3:0] len,
                             input logic [2:0] size, input logic [1:0] burst);
    logic [31:0] d;
    exp_aw.push_back({a, id, len, size, burst});
    for (int k = 0; k <= int'(len); k++) begin
      d = $urandom;
      wq.push_back(d);
      exp_w.push_back({d, strb_of(a, k, len, size, burst), 1'(k == int'(len)), id});
    end
  endtask

  task automatic run(input logic [31:0] a, input logic [3:0] id, input logic [3:0] len,
                     input logic [2:0] size, input logic [1:0] burst, input logic [1:0] resp,
                     input logic [3:0] bid, input bit never, input int bd);
    int w0, a0, n;
    int unsigned s;
    bit rej;
    done_t dd;
    w0 = w_seen;
    a0 = aw_seen;
    n = 0;
    s = 1 << size;
    rej = size > 2 || burst == 3 || (burst == 2 && !(len inside {1, 3, 7, 15})) || (burst == 2 && a % s != 0);
    if (rej) begin
      dd.v = {2'b10, 3'b100};
      dd.kind = 0;
    end else begin
      push_expect(a, id, len, size, burst);
      dd.v = never ? {2'b10, 3'b010} : {resp, 2'b00, 1'(bid != id)};
      dd.kind = never ? 1 : 2;
    end
    exp_d.push_back(dd);
    b_resp = resp;
    b_id = bid;
    b_never = never;
    b_delay = bd;
    issue(a, id, len, size, burst);
    while (exp_d.size() > 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (exp_d.size() > 0) begin
      chk("completion_timeout", 0, 1);
      flush();
    end
    chk("beat_count", w_seen - w0, rej ? 0 : int'(len) + 1);
    if (rej) chk("aw_quiet", aw_seen - a0, 0);
    repeat (2) @(posedge clk);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    logic [2:0] sz;
    logic [1:0] bu;
    logic [3:0] ln, id;
    logic [31:0] ad;
    repeat (3) @(negedge clk);
    chk("reset_ctrl", {cmd_ready, wr_ready, AWVALID, WVALID, WLAST, BREADY, done, busy}, 0);
    chk("reset_w", {WDATA, WSTRB, WID}, 0);
    reset = 1;
    run(32'h100, 4'd5, 4'd3, 3'd2, 2'd1, 2'd0, 4'd5, 0, 2);
    run(32'h102, 4'd1, 4'd1, 3'd2, 2'd1, 2'd1, 4'd1, 0, 1);
    run(32'h101, 4'd2, 4'd2, 3'd0, 2'd0, 2'd0, 4'd2, 0, 0);
    run(32'h100, 4'd3, 4'd2, 3'd2, 2'd2, 2'd0, 4'd3, 0, 0);
    run(32'h100, 4'd3, 4'd1, 3'd3, 2'd1, 2'd0, 4'd3, 0, 0);
    run(32'h100, 4'd3, 4'd1, 3'd2, 2'd3, 2'd0, 4'd3, 0, 0);
    run(32'h102, 4'd3, 4'd3, 3'd2, 2'd2, 2'd0, 4'd3, 0, 0);
    run(32'h106, 4'd6, 4'd3, 3'd1, 2'd2, 2'd2, 4'd6, 0, 3);
    wmode = 1;
    gaps = 1;
    aw_rand = 1;
    run(32'h300, 4'd7, 4'd7, 3'd2, 2'd1, 2'd0, 4'd7, 0, 4);
    wmode = 0;
    gaps = 0;
    aw_rand = 0;
    run(32'h400, 4'd5, 4'd1, 3'd2, 2'd1, 2'd0, 4'd5, 1, 0);
    run(32'h500, 4'd5, 4'd2, 3'd2, 2'd1, 2'd3, 4'd3, 0, 1);
    @(posedge clk);
    #1;
    BVALID = 1;
    BID = 4'd5;
    repeat (3) begin
      @(negedge clk);
      chk("bready_idle", BREADY, 0);
    end
    @(posedge clk);
    #1;
    BVALID = 0;
    n = 0;
    push_expect(32'h200, 4'd9, 4'd7, 3'd2, 2'd1);
    ad = w_seen;
    issue(32'h200, 4'd9, 4'd7, 3'd2, 2'd1);
    while (w_seen < int'(ad) + 2 && n < 500) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    #2;
    reset = 0;
    #1;
    chk("midburst_ctrl", {cmd_ready, wr_ready, AWVALID, WVALID, WLAST, BREADY, done, busy}, 0);
    chk("midburst_aw", {AWADDR, AWID, AWLEN, AWSIZE, AWBURST}, 0);
    chk("midburst_w", {WDATA, WSTRB, WID}, 0);
    chk("midburst_status", {done_resp, done_flags}, 0);
    flush();
    repeat (3) @(negedge clk);
    reset = 1;
    run(32'h600, 4'd4, 4'd2, 3'd2, 2'd1, 2'd0, 4'd4, 0, 1);
    for (int i = 0; i < 25; i++) begin
      bu = ($urandom_range(7) == 0) ? 2'd3 : 2'($urandom_range(2));
      sz = ($urandom_range(5) == 0) ? 3'd3 : 3'($urandom_range(2));
      ln = 4'($urandom_range(15));
      id = 4'($urandom_range(15));
      ad = 32'h1000 + $urandom_range(255);
      if (bu == 2 && $urandom_range(3) != 0) begin
        ln = 4'((2 << $urandom_range(3)) - 1);
        ad = ad & ~((32'd1 << sz) - 1);
      end
      wmode = $urandom_range(2);
      gaps = 1'($urandom_range(1));
      aw_rand = 1'($urandom_range(1));
      run(ad, id, ln, sz, bu, 2'($urandom_range(3)), ($urandom_range(4) == 0) ? ~id : id,
          $urandom_range(9) == 0, $urandom_range(10));
    end
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule

// File: doc/axi_burst_write_master.md
Name: axi_burst_write_master

Overview:
Parametrised, synthesizable AXI3-style write-burst master that replaces hand-driven write-channel stimulus. It accepts one burst command and a stream of data words from local logic, then issues the AW and W channels. It computes WLAST and byte strobes, collects the B response, and reports status. Bus widths follow the team's AXI signal-width conventions, so it drops straight onto the existing AXI signal bundle.

Parameters:
WIDTH, 32, data and address width; byte lanes NB = WIDTH/8; ID and LEN fields are NB bits wide.
SIZE, 3, AxSIZE width; AxBURST and xRESP are SIZE-1 bits wide.
TIMEOUT, 256, max cycles in RESP waiting for BVALID; counter width is $clog2(TIMEOUT+1).

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  command accepted while high with cmd_valid
cmd_addr  in  WIDTH  start byte address
cmd_id  in  NB  transaction ID
cmd_len  in  NB  beats-1
cmd_size  in  SIZE  log2 bytes per beat
cmd_burst  in  SIZE-1  00 FIXED, 01 INCR, 10 WRAP
wr_valid  in  1  data word available
wr_ready  out  1  data word consumed
wr_data  in  WIDTH  write data
AWVALID/AWREADY  out/in  1  address handshake
AWADDR AWID AWLEN AWSIZE AWBURST  out  WIDTH/NB/NB/SIZE/SIZE-1  registered copies of cmd fields
WVALID/WREADY  out/in  1  data handshake
WDATA  out  WIDTH  beat data
WSTRB  out  NB  byte strobes
WLAST  out  1  final beat
WID  out  NB  equals AWID
BVALID  in  1  response valid
BREADY  out  1  response ready
BID  in  NB  response ID
BRESP  in  SIZE-1  response code
busy  out  1  state != IDLE
done  out  1  one-cycle completion pulse
done_resp  out  SIZE-1  BRESP, or 2'b10 on reject/timeout
done_flags  out  3  {reject, timeout, id_mismatch}

Behaviour:
- Reset (reset=0, async) forces state IDLE. All outputs go low/zero: cmd_ready, wr_ready, AWVALID, WVALID, WLAST, WSTRB, BREADY, done, done_resp, done_flags, and all AW/W buses. Beat and timeout counters clear. This applies mid-burst; no completion is reported for the aborted burst.
- FSM states: IDLE -> ADDR -> DATA -> RESP -> IDLE. cmd_ready = (state==IDLE).
- Command validation at accept (cycle N). Reject when any of the following holds:
  - cmd_size > log2(NB);
  - cmd_burst==11;
  - WRAP with cmd_len not in {1,3,7,15};
  - WRAP with cmd_addr not aligned to 1<<cmd_size.
- On reject: no bus activity; done=1 at N+1 with done_resp=10 and flags=100; state stays IDLE.
- ADDR: AWVALID=1 from N+1 with all AW fields registered and stable until AWREADY. At handshake cycle M, drop AWVALID at M+1 and enter DATA. AW always completes before any W beat.
- DATA: one-entry W output register.
  - wr_ready = (state==DATA) && (!WVALID || WREADY) && (beats_loaded <= cmd_len).
  - On a wr_valid&&wr_ready cycle, load WDATA, WSTRB and WLAST; WVALID goes high the next cycle.
  - WVALID, WDATA, WSTRB and WLAST are held while WVALID && !WREADY.
  - WLAST=1 exactly on beat cmd_len (0-based).
  - After the last W handshake, enter RESP.
- WSTRB per beat: span = (1<<(1<<size))-1.
  - INCR beat 0: span << (addr mod NB), with bytes below addr mod NB cleared (unaligned start).
  - INCR later beats: span << (aligned_addr_k mod NB), where aligned_addr_k = (addr & ~((1<<size)-1)) + k<<size.
  - FIXED: beat-0 strobe on every beat.
  - WRAP: address wraps at boundary (cmd_len+1)<<size; strobe follows the wrapped address.
- RESP: BREADY=1 and the timeout counter increments each cycle.
  - On the BVALID&&BREADY cycle K: BREADY=0 at K+1, done=1 at K+1, done_resp=BRESP, id_mismatch=(BID!=AWID); return to IDLE.
  - If the counter reaches TIMEOUT first: done with resp 10, flags 010, BREADY dropped, IDLE.
  - BVALID arriving in the same cycle as expiry counts as a valid response; it wins over timeout.
- done_resp/done_flags are valid only while done=1, zero otherwise.
- Any BVALID outside RESP is ignored; BREADY stays 0.

Test Plan:
- INCR addr=0x100 len=3 size=2 id=5, AWREADY/WREADY tied 1, BVALID/BRESP=00/BID=5 after 2 cycles -> AWADDR=0x100 AWLEN=3; 4 beats WSTRB=1111; WLAST only on beat 3; done with resp 00, flags 000.
- INCR addr=0x102 len=1 size=2 -> WSTRB 1100 then 1111. FIXED addr=0x101 size=0 len=2 -> WSTRB 0010 on all 3 beats.
- WRAP len=2, plus size=3 on WIDTH=32 -> each: done one cycle after accept, resp 10, flags 100, AWVALID never asserted.
- Backpressure: WREADY toggled 1010, wr_valid gaps -> WVALID/WDATA/WSTRB/WLAST stable while stalled; data order preserved; exactly cmd_len+1 beats.
- TIMEOUT=16, BVALID held 0 -> done 16 cycles after RESP entry with flags 010; BID=3 vs AWID=5 on another run -> flags 001.
- Reset asserted in DATA after beat 1 -> all outputs 0 immediately; after release, a new command runs correctly from IDLE.
